tick_pwm: RTL and testbench

Tick-paced PWM generator that consumes the single-cycle `strobe` of a `counter_with_strobe` prescaler. It counts ticks within a programmable period and drives a duty-cycle output. Period/duty updates arrive over a valid/ready handshake and are applied only on period boundaries, so the output never glitches. It sits directly downstream of the prescaler, which sets the PWM time base.

---
 rtl/tick_pwm.sv | 108 ++++++++++
 tb/tb_tick_pwm.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/tick_pwm.sv
// Tick-paced PWM generator.
// Counts prescaler ticks within a programmable period and drives a
// registered duty-cycle output. New period/duty values arrive over a
// valid/ready handshake and are applied only on period boundaries
// (or immediately when idle), so the output never glitches mid-period.
module tick_pwm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] period_in,
  input  logic [WIDTH-1:0] duty_in,
  output logic             pwm_out,
  output logic             period_done
);

  logic [WIDTH-1:0] phase, period_q, duty_q, period_p, duty_p;
  logic             pend;

  logic [WIDTH-1:0] phase_n, period_n, duty_n, period_p_n, duty_p_n;
  logic             pend_n, done_n, pwm_n;
  logic             xfer, idle, wrap;

  assign load_ready = !pend;
  assign xfer       = load_valid && !pend;
  assign idle       = (period_q == '0);
  // period_q is nonzero whenever wrap is evaluated in RUN, so the
  // subtraction cannot underflow there.
  assign wrap       = !idle && tick && (phase >= period_q - WIDTH'(1));

  // Next-state: phase advance, wrap handling and load scheduling.
  always_comb begin
    phase_n    = phase;
    period_n   = period_q;
    duty_n     = duty_q;
    period_p_n = period_p;
    duty_p_n   = duty_p;
    pend_n     = pend;
    done_n     = 1'b0;

    if (idle) begin
      // Idle ignores ticks; a captured load goes live one edge later.
      phase_n = '0;
      if (pend) begin
        period_n = period_p;
        duty_n   = duty_p;
        pend_n   = 1'b0;
      end else if (xfer) begin
        period_p_n = period_in;
        duty_p_n   = duty_in;
        pend_n     = 1'b1;
      end
    end else begin
      if (tick) begin
        if (wrap) begin
          phase_n = '0;
          done_n  = 1'b1;
        end else begin
          phase_n = phase + WIDTH'(1);
        end
      end
      if (wrap) begin
        // A load landing on the wrap edge bypasses the pending slot.
        if (xfer) begin
          period_n = period_in;
          duty_n   = duty_in;
        end else if (pend) begin
          period_n = period_p;
          duty_n   = duty_p;
          pend_n   = 1'b0;
        end
      end else if (xfer) begin
        period_p_n = period_in;
        duty_p_n   = duty_in;
        pend_n     = 1'b1;
      end
    end

    pwm_n = (phase_n < duty_n) && (period_n != '0);
  end

  // State and registered outputs; async active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase       <= '0;
      period_q    <= '0;
      duty_q      <= '0;
      period_p    <= '0;
      duty_p      <= '0;
      pend        <= 1'b0;
      pwm_out     <= 1'b0;
      period_done <= 1'b0;
    end else begin
      phase       <= phase_n;
      period_q    <= period_n;
      duty_q      <= duty_n;
      period_p    <= period_p_n;
      duty_p      <= duty_p_n;
      pend        <= pend_n;
      pwm_out     <= pwm_n;
      period_done <= done_n;
    end
  end

endmodule

// File: tb/tb_tick_pwm.sv
// Scoreboard bench for tick_pwm: a driver applies stimulus at the falling
// edge and pushes the expected post-edge outputs from a tick-count model;
// a monitor pops and compares shortly after each rising edge.
module tb_tick_pwm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [7:0] period_in = '0;
  logic [7:0] duty_in = '0;
  logic       pwm_out;
  logic       period_done;

  tick_pwm #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .load_valid(load_valid), .load_ready(load_ready),
    .period_in(period_in), .duty_in(duty_in),
    .pwm_out(pwm_out), .period_done(period_done)
  );

  always #5 clk = ~clk;

  typedef struct { bit pwm; bit done; bit ready; } exp_t;
  typedef struct { int per; int duty; } cfg_t;

  exp_t exp_q[$];
  cfg_t pend_q[$];
  int   m_per, m_duty, m_k;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic act, input bit want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_per = 0; m_duty = 0; m_k = 0;
    pend_q.delete();
  endtask

  // One clock of stimulus plus the model's view of what that edge does.
  task automatic step(input bit t, input bit lv, input int p, input int d);
    bit   acc, done;
    cfg_t c;
    exp_t e;
    @(negedge clk);
    tick = t; load_valid = lv; period_in = 8'(p); duty_in = 8'(d);
    acc  = lv && (pend_q.size() == 0);
    done = 0;
    c.per = p; c.duty = d;
    if (m_per == 0) begin
      m_k = 0;
      if (pend_q.size() > 0) begin
        c = pend_q.pop_front();
        m_per = c.per; m_duty = c.duty;
      end else if (acc) pend_q.push_back(c);
    end else if (t && (m_k + 1 == m_per)) begin
      m_k = 0; done = 1;
      if (acc) begin
        m_per = p; m_duty = d;
      end else if (pend_q.size() > 0) begin
        c = pend_q.pop_front();
        m_per = c.per; m_duty = c.duty;
      end
    end else begin
      if (t) m_k++;
      if (acc) pend_q.push_back(c);
    end
    e.pwm = (m_per != 0) && (m_k < m_duty);
    e.done = done;
    e.ready = (pend_q.size() == 0);
    exp_q.push_back(e);
  endtask

  // Monitor: compare each expected entry against the DUT after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pwm_out", pwm_out, e.pwm);
      chk("period_done", period_done, e.done);
      chk("load_ready", load_ready, e.ready);
    end
  end

  initial begin
    int n, p, d;
    model_reset();
    #12;
    chk("rst_pwm", pwm_out, 1'b0);
    chk("rst_done", period_done, 1'b0);
    chk("rst_ready", load_ready, 1'b1);
    @(negedge clk); rst = 1'b1;

    // ticks while idle produce nothing
    repeat (4) step(1, 0, 0, 0);

    // basic PWM: period 4 duty 1, tick every cycle
    step(0, 1, 4, 1);
    repeat (14) step(1, 0, 0, 0);

    // sparse ticks: period 5 duty 2, tick every 3rd cycle
    step(0, 1, 5, 2);
    for (int i = 0; i < 45; i++) step(i % 3 == 0, 0, 0, 0);

    // deferred load: period 4 duty 1, load 2/2 while at phase 1
    step(0, 1, 4, 1);
    n = 0;
    while ((m_per != 4 || m_k != 1) && n < 40) begin step(1, 0, 0, 0); n++; end
    chk("reach_phase1", n < 40, 1'b1);
    step(0, 1, 2, 2);
    repeat (12) step(1, 0, 0, 0);

    // extremes: duty 0 period 3, then duty 7 period 4
    step(0, 1, 3, 0);
    repeat (10) step(1, 0, 0, 0);
    step(0, 1, 4, 7);
    repeat (12) step(1, 0, 0, 0);

    // load period 0 exactly on a wrap edge, then ticks stay silent
    n = 0;
    while (m_k != m_per - 1 && n < 40) begin step(1, 0, 0, 0); n++; end
    chk("reach_wrap", n < 40, 1'b1);
    step(1, 1, 0, 0);
    repeat (6) step(1, 0, 0, 0);

    // async reset mid-cycle while pwm_out=1 and a load is pending
    step(0, 1, 4, 3);
    step(0, 0, 0, 0);
    step(0, 1, 6, 2);
    @(negedge clk);
    tick = 1'b0; load_valid = 1'b0;
    chk("pre_rst_pwm", pwm_out, 1'b1);
    chk("pre_rst_pend", load_ready, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("arst_pwm", pwm_out, 1'b0);
    chk("arst_done", period_done, 1'b0);
    chk("arst_ready", load_ready, 1'b1);
    model_reset();
    @(negedge clk); rst = 1'b1;
    repeat (5) step(1, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) p = 0;
      else if ($urandom_range(0, 4) == 0) p = $urandom_range(1, 255);
      else p = $urandom_range(1, 6);
      d = $urandom_range(0, (p + 1 > 255) ? 255 : p + 1);
      step($urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0, p, d);
    end

    step(0, 0, 0, 0);
    @(negedge clk);
    chk("queue_drained", exp_q.size() == 0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
